// File: rtl/if_fetch_stage.sv
// Instruction fetch: sequential PCs, in-order imem requests, {pc,inst} buffer feeding IF/ID.
// Latency: an imem response in cycle N is presented on if_* in cycle N+1.
// Backpressure: requests issue only while in-flight + buffered < DEPTH; id_ready low holds if_*.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        arst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [63:0] if_pc
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic [63:0]   pc_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] drop_q;

    logic [63:0]   tag_mem [DEPTH];
    logic [AW-1:0] tag_rd_q;
    logic [AW-1:0] tag_wr_q;

    fetch_t        buf_mem [DEPTH];
    logic [AW-1:0] buf_rd_q;
    logic [AW-1:0] buf_wr_q;
    logic [CW-1:0] buf_cnt_q;

    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          buf_pop;
    fetch_t        head;

    // Requests are held off while reset is asserted so the memory never sees one from a reset state.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, buf_cnt_q};
    assign imem_req_valid = arst_n && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign rsp_take = imem_rsp_valid && (inflight_q != '0);
    assign rsp_drop = rsp_take && (drop_q != '0);
    assign rsp_keep = rsp_take && (drop_q == '0) && !redirect_valid;

    assign if_valid = (buf_cnt_q != '0);
    assign buf_pop  = if_valid && id_ready && !redirect_valid;
    assign head     = buf_mem[buf_rd_q];
    assign if_inst  = if_valid ? head.inst : NOP_INST;
    assign if_pc    = if_valid ? head.pc : 64'h0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_cnt_q  <= '0;
        end else begin
            // Dropped requests keep their credit until their response actually returns.
            inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_take);
            if (redirect_valid) begin
                pc_q      <= redirect_pc & ~64'h3;
                drop_q    <= inflight_q - CW'(rsp_take);
                tag_rd_q  <= '0;
                tag_wr_q  <= '0;
                buf_rd_q  <= '0;
                buf_wr_q  <= '0;
                buf_cnt_q <= '0;
            end else begin
                if (req_fire) begin
                    pc_q     <= pc_q + 64'd4;
                    tag_wr_q <= tag_wr_q + AW'(1);
                end
                if (rsp_drop) begin
                    drop_q <= drop_q - CW'(1);
                end
                if (rsp_keep) begin
                    tag_rd_q <= tag_rd_q + AW'(1);
                    buf_wr_q <= buf_wr_q + AW'(1);
                end
                if (buf_pop) begin
                    buf_rd_q <= buf_rd_q + AW'(1);
                end
                buf_cnt_q <= buf_cnt_q + CW'(rsp_keep) - CW'(buf_pop);
            end
        end
    end

    // Storage arrays need no reset: every read is qualified by the pointer/count state above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            buf_mem[buf_wr_q] <= '{pc: tag_mem[tag_rd_q], inst: imem_rsp_data};
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: reset vector table, directed corner sequences, randomized run vs queue model.
module tb_if_fetch_stage;
    localparam logic [63:0] RESET_PC = 64'h1000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;

    if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .arst_n(arst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int lat_lo  = 1;
    int lat_hi  = 1;

    // Memory responder: accepted addresses with the cycle their response is due.
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    // Reference model: next pc, outstanding requests with a still-wanted flag, delivered instructions.
    logic [63:0] m_pc;
    logic [63:0] m_os_pc[$];
    logic        m_os_live[$];
    logic [63:0] m_out_pc[$];
    logic [31:0] m_out_inst[$];

    logic        s_req_v, s_if_v;
    logic [63:0] s_addr, s_if_pc;
    logic [31:0] s_if_inst;

    typedef struct {
        logic        rdy;
        logic        rsp_v;
        logic [63:0] rsp_pc;
        logic        idr;
        logic        exp_req_v;
        logic [63:0] exp_addr;
        logic        exp_if_v;
        logic [63:0] exp_pc;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[63:34], 2'b11} ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
    endtask

    task automatic apply_reset();
        arst_n         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_inst", 64'(if_inst), 64'(NOP));
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        arst_n = 1'b1;
        pend_addr.delete(); pend_due.delete();
        m_os_pc.delete(); m_os_live.delete();
        m_out_pc.delete(); m_out_inst.delete();
        m_pc = RESET_PC;
        cyc  = 0;
    endtask

    // One clock cycle: drive inputs at the negedge, sample and compare 1 ns later, advance model.
    task automatic tick(input logic rdy, input logic idr, input logic redir,
                        input logic [63:0] rpc, input logic spur);
        logic        from_mem, exp_req_v, m_rsp, live;
        logic [63:0] pc;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        from_mem       = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
        imem_rsp_valid = from_mem || (spur && pend_addr.size() == 0);
        imem_rsp_data  = from_mem ? mem_word(pend_addr[0]) : 32'($urandom);
        #1;
        s_req_v = imem_req_valid; s_addr = imem_req_addr;
        s_if_v = if_valid; s_if_pc = if_pc; s_if_inst = if_inst;

        exp_req_v = !redir && (m_os_pc.size() + m_out_pc.size() < DEPTH);
        chk("req_valid", 64'(s_req_v), 64'(exp_req_v));
        chk("req_addr", s_addr, m_pc);
        chk("if_valid", 64'(s_if_v), 64'(m_out_pc.size() > 0));
        chk("if_pc", s_if_pc, (m_out_pc.size() > 0) ? m_out_pc[0] : 64'd0);
        chk("if_inst", 64'(s_if_inst), 64'((m_out_pc.size() > 0) ? m_out_inst[0] : NOP));

        m_rsp = imem_rsp_valid && (m_os_pc.size() > 0);
        if (redir) begin
            if (m_rsp) begin void'(m_os_pc.pop_front()); void'(m_os_live.pop_front()); end
            foreach (m_os_live[i]) m_os_live[i] = 1'b0;
            m_out_pc.delete(); m_out_inst.delete();
            m_pc = {rpc[63:2], 2'b00};
        end else begin
            if (idr && m_out_pc.size() > 0) begin
                void'(m_out_pc.pop_front()); void'(m_out_inst.pop_front());
            end
            if (m_rsp) begin
                pc   = m_os_pc.pop_front();
                live = m_os_live.pop_front();
                if (live) begin m_out_pc.push_back(pc); m_out_inst.push_back(mem_word(pc)); end
            end
            if (exp_req_v && rdy) begin
                m_os_pc.push_back(m_pc); m_os_live.push_back(1'b1);
                m_pc = m_pc + 64'd4;
            end
        end

        if (from_mem) begin void'(pend_addr.pop_front()); void'(pend_due.pop_front()); end
        if (s_req_v && rdy) begin
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic found;
        // 1-cycle latency start-up from RESET_PC, fully spelled out.
        tbl[0] = '{1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 64'h1004, 1'b1, 1'b0, 64'h1008, 1'b1, 64'h1000};
        tbl[3] = '{1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004};
        tbl[4] = '{1'b1, 1'b1, 64'h1008, 1'b1, 1'b1, 64'h100C, 1'b0, 64'h0};
        tbl[5] = '{1'b1, 1'b1, 64'h100C, 1'b1, 1'b0, 64'h1010, 1'b1, 64'h1008};
        tbl[6] = '{1'b1, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1010, 1'b1, 64'h100C};

        #2;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rsp_v;
            imem_rsp_data  = mem_word(tbl[i].rsp_pc);
            id_ready       = tbl[i].idr;
            redirect_valid = 1'b0;
            #1;
            chk("tbl_req_valid", 64'(imem_req_valid), 64'(tbl[i].exp_req_v));
            chk("tbl_req_addr", imem_req_addr, tbl[i].exp_addr);
            chk("tbl_if_valid", 64'(if_valid), 64'(tbl[i].exp_if_v));
            chk("tbl_if_pc", if_pc, tbl[i].exp_pc);
            chk("tbl_if_inst", 64'(if_inst), 64'(tbl[i].exp_if_v ? mem_word(tbl[i].exp_pc) : NOP));
            @(posedge clk);
            @(negedge clk);
        end

        // Stall for 5 cycles with a full credit window, then drain.
        @(negedge clk);
        apply_reset();
        lat_lo = 1; lat_hi = 1;
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, 0, 0, 0);
            chk("stall_req_valid", 64'(s_req_v), 64'd0);
            chk("stall_if_pc", s_if_pc, 64'h1000);
        end
        for (int k = 0; k < 10; k++) tick(1, 1, 0, 0, 0);

        // Redirect to an unaligned target with two 3-cycle requests outstanding.
        @(negedge clk);
        apply_reset();
        lat_lo = 3; lat_hi = 3;
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 1, 64'h2002, 0);
        tick(1, 1, 0, 0, 0);
        chk("redir_addr", s_addr, 64'h2000);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1, 1, 0, 0, 0);
            found = s_if_v;
        end
        chk("redir_first_valid", 64'(found), 64'd1);
        chk("redir_first_pc", s_if_pc, 64'h2000);

        // Redirect coinciding with a response and a pending pop.
        @(negedge clk);
        apply_reset();
        lat_lo = 1; lat_hi = 1;
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 1, 64'h3000, 0);
        chk("redir_pop_pending", 64'(s_if_v), 64'd1);
        tick(1, 1, 0, 0, 0);
        chk("redir_buf_empty", 64'(s_if_v), 64'd0);
        chk("redir_nop", 64'(s_if_inst), 64'(NOP));
        for (int k = 0; k < 4; k++) tick(1, 1, 0, 0, 0);

        // PC wraps from the top of the address space.
        @(negedge clk);
        apply_reset();
        tick(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        tick(1, 1, 0, 0, 0);
        chk("wrap_req_valid", 64'(s_req_v), 64'd1);
        chk("wrap_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(1, 1, 0, 0, 0);
        chk("wrap_addr_zero", s_addr, 64'h0);
        for (int k = 0; k < 4; k++) tick(1, 1, 0, 0, 0);

        // Response with nothing outstanding must leave state untouched.
        @(negedge clk);
        apply_reset();
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0);
        chk("spur_if_valid", 64'(s_if_v), 64'd0);
        chk("spur_req_valid", 64'(s_req_v), 64'd1);

        // Asynchronous reset with a full buffer.
        @(negedge clk);
        apply_reset();
        for (int k = 0; k < 4; k++) tick(1, 0, 0, 0, 0);
        chk("full_if_valid", 64'(s_if_v), 64'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("midrst_if_valid", 64'(if_valid), 64'd0);
        apply_reset();
        tick(1, 1, 0, 0, 0);
        chk("restart_addr", s_addr, RESET_PC);
        chk("restart_req_valid", 64'(s_req_v), 64'd1);

        // Randomized traffic against the model.
        @(negedge clk);
        apply_reset();
        lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 1500; k++) begin
            tick($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7,
                 $urandom_range(24, 0) == 0, {$urandom, $urandom}, $urandom_range(29, 0) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
